edge_nic: RTL and testbench
===========================

# edge_nic

Edge network interface that sits between a host agent and one boundary link of the mesh: one of the north, south, east or west edge byte ports. It accepts whole packets from the host on a valid/ready interface and buffers them. It serializes each packet onto the 8-bit inbound edge link. It also deserializes the 8-bit outbound edge link back into whole packets for the host. One instance is placed per used edge link, outside the mesh top level.

## Interface
Parameters:
- MAX_LEN, 4: maximum payload bytes per packet (1..15).
- TX_DEPTH, 2: TX packet FIFO depth in packets (power of 2, ≥2).
- LEN_W, $clog2(MAX_LEN+1): width of length fields.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tx_valid  in  1  host packet offered
- tx_ready  out  1  FIFO can accept (not full)
- tx_dest_x  in  3  destination column
- tx_dest_y  in  3  destination row
- tx_len  in  LEN_W  payload byte count
- tx_data  in  MAX_LEN*8  payload; byte i = tx_data[8i+7:8i], byte 0 sent first
- tx_err  out  1  one-cycle pulse: offered packet had tx_len > MAX_LEN and was discarded
- link_out  out  8  byte stream into the mesh edge input
- link_in  in  8  byte stream from the mesh edge output
- rx_valid  out  1  received packet held
- rx_ready  in  1  host takes packet
- rx_dest_x, rx_dest_y  out  3 each  header coordinates of received packet
- rx_len  out  LEN_W  payload byte count
- rx_data  out  MAX_LEN*8  payload, same byte order; bytes ≥ rx_len are zero
- rx_err  out  1  one-cycle pulse: length byte > MAX_LEN, packet aborted
- rx_drop  out  1  one-cycle pulse: completed packet lost because the output register was occupied

## Operation
- Link format: idle byte 8'h00. Header byte {1'b1, dest_x[2:0], dest_y[2:0], 1'b0}. Length byte {(8-LEN_W)'0, len}. Then exactly len payload bytes, with any value including 8'h00. len 0 is legal: header and length only.
- TX handshake: transfer on tx_valid & tx_ready. tx_ready = !fifo_full and is independent of tx_valid. A packet with len > MAX_LEN is consumed (tx_ready honoured), not enqueued, and raises tx_err.
- TX FSM states:
  - T_IDLE: drives 00. Goes to T_HDR when the FIFO is non-empty.
  - T_HDR: drives the header byte.
  - T_LEN: drives the length byte. Goes to T_PAY if len > 0. Otherwise the FIFO entry is popped and the FSM goes to T_HDR if more packets are queued, else T_IDLE.
  - T_PAY: drives payload with a byte counter. After the last byte the entry is popped and the FSM goes to T_HDR if more packets are queued, else T_IDLE.
- TX packets are sent back-to-back with no idle gap. No backpressure exists on the link.
- RX FSM states:
  - R_IDLE: ignores bytes with bit7 = 0. A byte with bit7 = 1 latches dest_x/dest_y and goes to R_LEN.
  - R_LEN: len > MAX_LEN pulses rx_err and returns to R_IDLE. len 0 completes the packet. Otherwise the FSM goes to R_PAY.
  - R_PAY: bytes are collected by a counter. The last byte completes the packet.
- RX completion: if the output register is empty, or rx_valid & rx_ready in the same cycle, the packet loads and rx_valid is set. Otherwise the new packet is discarded, rx_drop pulses, and the held packet is kept.
- RX returns to R_IDLE on completion, so a header may immediately follow the last payload byte.

## Timing
- All outputs are registered.
- Reset values: link_out = 00, tx_ready = 1, rx_valid = 0, rx_* fields = 0, tx_err = rx_err = rx_drop = 0. Both FSMs go to idle and the FIFO empties.
- TX latency: accepted at cycle t, with the FIFO empty and the FSM idle:
  - header on link_out during t+1
  - length byte at t+2
  - payload at t+3 .. t+2+len
  - next queued header at t+3+len
- A push and a pop in the same cycle on a full FIFO are allowed only for the pop. tx_ready reflects occupancy before the edge.
- RX latency: the last byte sampled at edge c gives rx_valid = 1 after edge c. rx_valid drops after the edge where rx_valid & rx_ready, unless a new completion reloads it on that edge.
- Reset asserted mid-packet aborts both directions: link_out = 00 immediately (asynchronous), and the partial RX packet is lost.

## Structure
- The noc_params package gains:
  - COORD_W = 3
  - IDLE_BYTE = 8'h00
  - the header bit positions
  - the enums tx_state_e and rx_state_e
  - struct edge_pkt_t {dest_x, dest_y, len, data}
- Sub-module edge_pkt_fifo: a TX_DEPTH × edge_pkt_t synchronous FIFO with full/empty flags, asynchronous reset, and a pointer-wrap extra bit.
- TX FSM, RX FSM and the RX output register live in edge_nic.

## Test plan
- Single TX: dest (2,1), len 3, data 0x00_CC_BB_AA. Required link_out over cycles t+1..t+5: 0xA2, 0x03, 0xAA, 0xBB, 0xCC, then 0x00.
- Back-to-back TX: three packets, len 0, 2, 1, with TX_DEPTH 2. Required: tx_ready low once 2 are queued. The link carries contiguous headers and lengths with no 00 gap until the queue drains.
- Illegal TX: tx_len = 7 with MAX_LEN = 4. Required: tx_err pulses once and the link stays 00.
- RX loopback: link_out is wired to link_in and a len 4 packet is sent. Required: rx_valid exactly 1 cycle after the 4th payload byte, rx fields equal to the sent fields, and payload bytes equal to 00 decoded correctly.
- RX overflow and error: rx_ready held 0 while two packets arrive. Required: the first is held and rx_drop pulses at the second's completion. Then a length byte of 0x09 must give an rx_err pulse and a return to idle.
- Reset during T_PAY and R_PAY. Required: outputs take their reset values immediately. After release, a fresh packet is transmitted and received correctly.

Source files
------------

// File: rtl/edge_nic_pkg.sv
// Shared types and constants for the mesh edge network interface.
package edge_nic_pkg;

  localparam int unsigned COORD_W     = 3;
  localparam int unsigned PKT_MAX_LEN = 15;
  localparam int unsigned PKT_LEN_W   = 4;
  localparam int unsigned PKT_DATA_W  = PKT_MAX_LEN * 8;

  localparam logic [7:0]  IDLE_BYTE    = 8'h00;
  localparam int unsigned HDR_FLAG_BIT = 7;
  localparam int unsigned HDR_X_LSB    = 4;
  localparam int unsigned HDR_Y_LSB    = 1;

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_LEN, T_PAY} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LEN, R_PAY} rx_state_e;

  // Sized for the largest legal MAX_LEN; narrower instances leave upper bytes zero.
  typedef struct packed {
    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
    logic [PKT_LEN_W-1:0]  len;
    logic [PKT_DATA_W-1:0] data;
  } edge_pkt_t;

  function automatic logic [7:0] hdr_byte(input edge_pkt_t p);
    logic [7:0] b;
    b = '0;
    b[HDR_FLAG_BIT] = 1'b1;
    b[HDR_X_LSB +: COORD_W] = p.dest_x;
    b[HDR_Y_LSB +: COORD_W] = p.dest_y;
    return b;
  endfunction

  function automatic logic [7:0] pay_byte(input edge_pkt_t p, input logic [PKT_LEN_W-1:0] idx);
    return p.data[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/edge_nic_fifo.sv
// Packet FIFO for the TX path; exposes the head and the entry behind it.
module edge_pkt_fifo
  import edge_nic_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  edge_pkt_t                pkt_i,
  input  logic                     pop_i,
  output edge_pkt_t                head_o,
  output edge_pkt_t                next_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  edge_pkt_t        mem_q [DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;
  logic [PTR_W-1:0] rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (PTR_W+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign rd_nxt  = rd_q[PTR_W-1:0] + PTR_W'(1);
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];
  assign next_o  = mem_q[rd_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= pkt_i;
  end

endmodule

// File: rtl/edge_nic.sv
// Edge NIC: host packets serialized onto the inbound edge link, outbound link
// bytes reassembled into packets for the host.
module edge_nic
  import edge_nic_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 4,
  parameter int unsigned TX_DEPTH = 2,
  parameter int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [2:0]         tx_dest_x,
  input  logic [2:0]         tx_dest_y,
  input  logic [LEN_W-1:0]   tx_len,
  input  logic [MAX_LEN*8-1:0] tx_data,
  output logic               tx_err,
  output logic [7:0]         link_out,
  input  logic [7:0]         link_in,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [2:0]         rx_dest_x,
  output logic [2:0]         rx_dest_y,
  output logic [LEN_W-1:0]   rx_len,
  output logic [MAX_LEN*8-1:0] rx_data,
  output logic               rx_err,
  output logic               rx_drop
);

  localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

  // ---------------- TX ----------------
  edge_pkt_t            push_pkt, fifo_head, fifo_next, idle_pkt, follow_pkt;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 tx_len_ok, tx_push, pkt_done, follow_valid;
  logic [PKT_LEN_W-1:0] tx_nxt_idx;
  tx_state_e            tx_state_q;
  logic [PKT_LEN_W-1:0] tx_cnt_q;
  logic [7:0]           link_out_q;
  logic                 tx_err_q;

  assign tx_ready = ~fifo_full;

  // The packet following the current one may still be on the input port this
  // cycle, so the header byte is taken from the bypass when the FIFO lacks it.
  always_comb begin
    push_pkt        = '0;
    push_pkt.dest_x = tx_dest_x;
    push_pkt.dest_y = tx_dest_y;
    push_pkt.len    = PKT_LEN_W'(tx_len);
    push_pkt.data   = PKT_DATA_W'(tx_data);
    tx_len_ok       = (tx_len <= LEN_W'(MAX_LEN));
    tx_push         = tx_valid & ~fifo_full & tx_len_ok;
    idle_pkt        = fifo_empty ? push_pkt : fifo_head;
    follow_valid    = (fifo_count > CNT_W'(1)) | tx_push;
    follow_pkt      = (fifo_count > CNT_W'(1)) ? fifo_next : push_pkt;
    pkt_done        = ((tx_state_q == T_LEN) && (fifo_head.len == '0)) ||
                      ((tx_state_q == T_PAY) && (tx_cnt_q + PKT_LEN_W'(1) == fifo_head.len));
    tx_nxt_idx      = (tx_state_q == T_LEN) ? '0 : tx_cnt_q + PKT_LEN_W'(1);
  end

  edge_pkt_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pkt_i   (push_pkt),
    .pop_i   (pkt_done),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      link_out_q <= IDLE_BYTE;
      tx_err_q   <= 1'b0;
    end else begin
      tx_err_q <= tx_valid & ~fifo_full & ~tx_len_ok;
      case (tx_state_q)
        T_IDLE: begin
          if (!fifo_empty || tx_push) begin
            tx_state_q <= T_HDR;
            link_out_q <= hdr_byte(idle_pkt);
          end else begin
            link_out_q <= IDLE_BYTE;
          end
        end
        T_HDR: begin
          tx_state_q <= T_LEN;
          link_out_q <= {4'b0000, fifo_head.len};
        end
        T_LEN, T_PAY: begin
          if (pkt_done) begin
            if (follow_valid) begin
              tx_state_q <= T_HDR;
              link_out_q <= hdr_byte(follow_pkt);
            end else begin
              tx_state_q <= T_IDLE;
              link_out_q <= IDLE_BYTE;
            end
          end else begin
            tx_state_q <= T_PAY;
            tx_cnt_q   <= tx_nxt_idx;
            link_out_q <= pay_byte(fifo_head, tx_nxt_idx);
          end
        end
        default: begin
          tx_state_q <= T_IDLE;
          link_out_q <= IDLE_BYTE;
        end
      endcase
    end
  end

  assign link_out = link_out_q;
  assign tx_err   = tx_err_q;

  // ---------------- RX ----------------
  rx_state_e            rx_state_q;
  logic [COORD_W-1:0]   hdr_x_q, hdr_y_q;
  logic [LEN_W-1:0]     asm_len_q, rx_cnt_q;
  logic [MAX_LEN*8-1:0] asm_q, asm_fill;
  logic                 rx_complete, rx_load;
  logic [LEN_W-1:0]     cmp_len;
  logic [MAX_LEN*8-1:0] cmp_data;
  logic                 rx_valid_q, rx_err_q, rx_drop_q;
  logic [COORD_W-1:0]   rx_x_q, rx_y_q;
  logic [LEN_W-1:0]     rx_len_q;
  logic [MAX_LEN*8-1:0] rx_data_q;

  always_comb begin
    asm_fill = asm_q;
    asm_fill[{rx_cnt_q, 3'b000} +: 8] = link_in;
    rx_complete = 1'b0;
    cmp_len     = '0;
    cmp_data    = '0;
    if ((rx_state_q == R_LEN) && (link_in == 8'h00)) begin
      rx_complete = 1'b1;
    end
    if ((rx_state_q == R_PAY) && (rx_cnt_q + LEN_W'(1) == asm_len_q)) begin
      rx_complete = 1'b1;
      cmp_len     = asm_len_q;
      cmp_data    = asm_fill;
    end
    rx_load = rx_complete & (~rx_valid_q | rx_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      hdr_x_q    <= '0;
      hdr_y_q    <= '0;
      asm_len_q  <= '0;
      rx_cnt_q   <= '0;
      asm_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_drop_q  <= 1'b0;
      rx_x_q     <= '0;
      rx_y_q     <= '0;
      rx_len_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_err_q  <= 1'b0;
      rx_drop_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (rx_load) begin
        rx_valid_q <= 1'b1;
        rx_x_q     <= hdr_x_q;
        rx_y_q     <= hdr_y_q;
        rx_len_q   <= cmp_len;
        rx_data_q  <= cmp_data;
      end else if (rx_complete) begin
        rx_drop_q <= 1'b1;
      end
      case (rx_state_q)
        R_IDLE: begin
          if (link_in[HDR_FLAG_BIT]) begin
            hdr_x_q    <= link_in[HDR_X_LSB +: COORD_W];
            hdr_y_q    <= link_in[HDR_Y_LSB +: COORD_W];
            rx_state_q <= R_LEN;
          end
        end
        R_LEN: begin
          if (link_in > 8'(MAX_LEN)) begin
            rx_err_q   <= 1'b1;
            rx_state_q <= R_IDLE;
          end else if (link_in == 8'h00) begin
            rx_state_q <= R_IDLE;
          end else begin
            asm_len_q  <= link_in[LEN_W-1:0];
            rx_cnt_q   <= '0;
            asm_q      <= '0;
            rx_state_q <= R_PAY;
          end
        end
        R_PAY: begin
          if (rx_complete) begin
            rx_state_q <= R_IDLE;
          end else begin
            asm_q    <= asm_fill;
            rx_cnt_q <= rx_cnt_q + LEN_W'(1);
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_dest_x = rx_x_q;
  assign rx_dest_y = rx_y_q;
  assign rx_len    = rx_len_q;
  assign rx_data   = rx_data_q;
  assign rx_err    = rx_err_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_edge_nic.sv
// Directed bench for edge_nic (MAX_LEN 4, TX_DEPTH 2).
module tb_edge_nic;

  logic        clk, rst;
  logic        tx_valid, tx_ready, tx_err;
  logic [2:0]  tx_dest_x, tx_dest_y, tx_len;
  logic [31:0] tx_data;
  logic [7:0]  link_out, link_in, link_drv;
  logic        loop;
  logic        rx_valid, rx_ready, rx_err, rx_drop;
  logic [2:0]  rx_dest_x, rx_dest_y, rx_len;
  logic [31:0] rx_data;

  int errors = 0;
  int checks = 0;

  assign link_in = loop ? link_out : link_drv;

  edge_nic #(.MAX_LEN(4), .TX_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_len(tx_len), .tx_data(tx_data),
    .tx_err(tx_err), .link_out(link_out), .link_in(link_in),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_dest_x(rx_dest_x), .rx_dest_y(rx_dest_y), .rx_len(rx_len), .rx_data(rx_data),
    .rx_err(rx_err), .rx_drop(rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  x;
    logic [2:0]  y;
    logic [2:0]  len;
    logic [31:0] data;
    logic [7:0]  exp_hdr;
    logic [31:0] exp_rx_data;
  } vec_t;

  vec_t tbl [5];
  logic [7:0] cap_b [10];
  logic [7:0] exp_b [10];
  logic       cap_r [10];
  logic       exp_r [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] x, input logic [2:0] y, input logic [2:0] len,
                      input logic [31:0] d);
    logic got, rdy;
    got = 1'b0;
    tx_valid = 1'b1; tx_dest_x = x; tx_dest_y = y; tx_len = len; tx_data = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); rdy = tx_ready;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
    end
    tx_valid = 1'b0;
    chk("push_accept", 32'(got), 32'd1);
  endtask

  task automatic drive(input logic [7:0] b);
    link_drv = b;
    @(posedge clk); #1;
  endtask

  // Send one packet through the loopback and check link bytes and the RX result.
  task automatic run_rec(input vec_t v);
    logic [31:0] d;
    d = v.data;
    @(posedge clk); #1;
    push(v.x, v.y, v.len, v.data);
    @(negedge clk); chk("tx_hdr", 32'(link_out), 32'(v.exp_hdr));
    @(negedge clk); chk("tx_lenbyte", 32'(link_out), 32'(v.len));
    if (v.len == 3'd0) chk("rx_valid_early", 32'(rx_valid), 32'd0);
    for (int i = 0; i < int'(v.len); i++) begin
      @(negedge clk);
      chk("tx_payload", 32'(link_out), 32'(d[8*i +: 8]));
      if (i == int'(v.len) - 1) chk("rx_valid_early", 32'(rx_valid), 32'd0);
    end
    @(negedge clk);
    chk("tx_idle_after", 32'(link_out), 32'h00);
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_dest_x", 32'(rx_dest_x), 32'(v.x));
    chk("rx_dest_y", 32'(rx_dest_y), 32'(v.y));
    chk("rx_len", 32'(rx_len), 32'(v.len));
    chk("rx_data", rx_data, v.exp_rx_data);
    @(negedge clk); chk("rx_valid_taken", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{x: 3'd2, y: 3'd1, len: 3'd3, data: 32'h00CCBBAA, exp_hdr: 8'hA2, exp_rx_data: 32'h00CCBBAA};
    tbl[1] = '{x: 3'd7, y: 3'd7, len: 3'd0, data: 32'h00000000, exp_hdr: 8'hFE, exp_rx_data: 32'h00000000};
    tbl[2] = '{x: 3'd0, y: 3'd0, len: 3'd4, data: 32'h44332211, exp_hdr: 8'h80, exp_rx_data: 32'h44332211};
    tbl[3] = '{x: 3'd5, y: 3'd3, len: 3'd1, data: 32'h778899EE, exp_hdr: 8'hD6, exp_rx_data: 32'h000000EE};
    tbl[4] = '{x: 3'd1, y: 3'd6, len: 3'd2, data: 32'h00000055, exp_hdr: 8'h9C, exp_rx_data: 32'h00000055};
    exp_b = '{8'h92, 8'h00, 8'hB8, 8'h02, 8'h5A, 8'hA5, 8'hE4, 8'h01, 8'h3C, 8'h00};
    exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; loop = 1'b0; link_drv = 8'h00; rx_ready = 1'b0;
    tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_len = '0; tx_data = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_link_out", 32'(link_out), 32'h00);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_fields", {23'b0, rx_dest_x, rx_dest_y, rx_len}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_pulses", {29'b0, tx_err, rx_err, rx_drop}, 32'd0);
    rst = 1'b0;

    // Table: TX serialization and RX loopback
    loop = 1'b1; rx_ready = 1'b1;
    for (int r = 0; r < 5; r++) run_rec(tbl[r]);

    // Back-to-back TX with a full FIFO
    loop = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        push(3'd1, 3'd1, 3'd0, 32'h0);
        push(3'd3, 3'd4, 3'd2, 32'h0000A55A);
        push(3'd6, 3'd2, 3'd1, 32'h0000003C);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          cap_b[i] = link_out;
          cap_r[i] = tx_ready;
        end
      end
    join
    for (int i = 0; i < 10; i++) begin
      chk("b2b_link", 32'(cap_b[i]), 32'(exp_b[i]));
      chk("b2b_ready", 32'(cap_r[i]), 32'(exp_r[i]));
    end

    // Illegal TX length
    @(posedge clk); #1;
    push(3'd2, 3'd2, 3'd7, 32'hDEADBEEF);
    @(negedge clk); chk("tx_err_pulse", 32'(tx_err), 32'd1); chk("illegal_link", 32'(link_out), 32'h00);
    @(negedge clk); chk("tx_err_once", 32'(tx_err), 32'd0); chk("illegal_link", 32'(link_out), 32'h00);
    @(negedge clk); chk("illegal_link", 32'(link_out), 32'h00);

    // RX overflow, length error, return to idle
    rx_ready = 1'b0;
    @(posedge clk); #1;
    drive(8'hBA); drive(8'h02); drive(8'h12); drive(8'h34);
    @(negedge clk);
    chk("ovf_first_valid", 32'(rx_valid), 32'd1);
    chk("ovf_first_x", 32'(rx_dest_x), 32'd3);
    chk("ovf_first_y", 32'(rx_dest_y), 32'd5);
    chk("ovf_first_len", 32'(rx_len), 32'd2);
    chk("ovf_first_data", rx_data, 32'h00003412);
    drive(8'hC0); drive(8'h01); drive(8'h77);
    @(negedge clk);
    chk("ovf_drop", 32'(rx_drop), 32'd1);
    chk("ovf_held_valid", 32'(rx_valid), 32'd1);
    chk("ovf_held_x", 32'(rx_dest_x), 32'd3);
    chk("ovf_held_data", rx_data, 32'h00003412);
    drive(8'h82); drive(8'h09);
    @(negedge clk);
    chk("rx_err_pulse", 32'(rx_err), 32'd1);
    chk("rx_drop_once", 32'(rx_drop), 32'd0);
    chk("err_held_len", 32'(rx_len), 32'd2);
    drive(8'h55);
    @(negedge clk); chk("rx_err_once", 32'(rx_err), 32'd0);
    rx_ready = 1'b1; drive(8'h00); rx_ready = 1'b0;
    @(negedge clk); chk("taken_valid", 32'(rx_valid), 32'd0);
    drive(8'hF0); drive(8'h00);
    @(negedge clk);
    chk("len0_valid", 32'(rx_valid), 32'd1);
    chk("len0_xy", {26'b0, rx_dest_x, rx_dest_y}, {26'b0, 3'd7, 3'd0});
    chk("len0_len", 32'(rx_len), 32'd0);
    chk("len0_data", rx_data, 32'd0);

    // Reset in the middle of a packet in both directions
    loop = 1'b1;
    @(posedge clk); #1;
    push(3'd4, 3'd4, 3'd4, 32'h01020304);
    @(negedge clk); chk("mid_hdr", 32'(link_out), 32'hC8);
    @(negedge clk);
    @(negedge clk); chk("mid_pay0", 32'(link_out), 32'h04);
    #2 rst = 1'b1;
    #1;
    chk("arst_link_out", 32'(link_out), 32'h00);
    chk("arst_tx_ready", 32'(tx_ready), 32'd1);
    chk("arst_rx_valid", 32'(rx_valid), 32'd0);
    chk("arst_rx_fields", {23'b0, rx_dest_x, rx_dest_y, rx_len}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_link", 32'(link_out), 32'h00);
      chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    end
    rx_ready = 1'b1;
    run_rec(tbl[2]);
    run_rec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
